// File: rtl/lfsr9_gen.sv
// 9-bit maximal-length Fibonacci LFSR (x^9 + x^5 + 1), one new value per clock.
// Optional build macro LFSR9_LOCKUP_RECOVERY_EN: escape the all-zero lock-up state to 9'h001.
module lfsr9_gen #(
  parameter logic [8:0] SEED = 9'h001
) (
  input  logic       clock,
  input  logic       reset,
  output logic [8:0] random
);

  logic [8:0] state_q;
  logic [8:0] state_d;
  logic       feedback_s;

  // Zero is the XOR lock-up state, so a zero seed would freeze the generator.
  if (SEED == 9'h000) begin : g_seed_check
    $error("lfsr9_gen: SEED must be nonzero");
  end

  // Next-state: shift left with the tap XOR entering bit 0.
  always_comb begin
    feedback_s = state_q[8] ^ state_q[4];
    state_d    = {state_q[7:0], feedback_s};
`ifdef LFSR9_LOCKUP_RECOVERY_EN
    if (state_q == 9'h000) begin
      state_d = 9'h001;
    end else begin
      state_d = {state_q[7:0], feedback_s};
    end
`endif
  end

  // State register; reset wins over shifting.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign random = state_q;

endmodule

// File: tb/tb_lfsr9_gen.sv
// Directed self-checking bench for lfsr9_gen: reset, first steps, full period,
// mid-run reset, non-default seed and the all-zero lock-up behaviour.
module tb_lfsr9_gen;

  logic       clock;
  logic       reset;
  logic [8:0] random;
  logic [8:0] random_seed;

  int n_pass;
  int n_total;

  lfsr9_gen dut (
    .clock  (clock),
    .reset  (reset),
    .random (random)
  );

  lfsr9_gen #(.SEED(9'h1A5)) dut_seed (
    .clock  (clock),
    .reset  (reset),
    .random (random_seed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    n_total++;
    if (random !== 9'h001) $display("FAIL reset_1cyc: got %h want %h", random, 9'h001);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (random !== 9'h001) $display("FAIL reset_hold[%0d]: got %h want %h", i, random, 9'h001);
      else n_pass++;
    end
  endtask

  task automatic check_first_steps(input string tag);
    logic [8:0] exp_q [5];
    exp_q = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h021};
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++;
      if (random !== exp_q[i]) $display("FAIL %s[%0d]: got %h want %h", tag, i, random, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_first_steps();
    check_first_steps("first_steps");
  endtask

  task automatic test_full_period();
    logic [8:0] start;
    bit         seen [512];
    int         distinct;
    int         first_ret;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    start = random;
    n_total++;
    if (start !== 9'h002) $display("FAIL period_start: got %h want %h", start, 9'h002);
    else n_pass++;
    distinct  = 0;
    first_ret = 0;
    for (int i = 0; i < 512; i++) seen[i] = 1'b0;
    for (int i = 1; i <= 511; i++) begin
      step();
      if (!seen[random]) distinct++;
      seen[random] = 1'b1;
      if (random === start && first_ret == 0) first_ret = i;
    end
    n_total++;
    if (first_ret != 511) $display("FAIL period_return: got %0d want %0d", first_ret, 511);
    else n_pass++;
    n_total++;
    if (distinct != 511) $display("FAIL period_distinct: got %0d want %0d", distinct, 511);
    else n_pass++;
    n_total++;
    if (seen[0] !== 1'b0) $display("FAIL period_zero: got %0d want %0d", seen[0], 0);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 200; i++) step();
    reset = 1'b1;
    step();
    n_total++;
    if (random !== 9'h001) $display("FAIL mid_reset: got %h want %h", random, 9'h001);
    else n_pass++;
    check_first_steps("mid_restart");
  endtask

  task automatic test_seed();
    reset = 1'b1;
    step();
    n_total++;
    if (random_seed !== 9'h1A5) $display("FAIL seed_reset: got %h want %h", random_seed, 9'h1A5);
    else n_pass++;
    reset = 1'b0;
    step();
    n_total++;
    if (random_seed !== 9'h14B) $display("FAIL seed_step: got %h want %h", random_seed, 9'h14B);
    else n_pass++;
  endtask

  task automatic test_lockup();
    reset = 1'b0;
    step();
    force dut.state_q = 9'h000;
    #1;
    release dut.state_q;
    n_total++;
    if (random !== 9'h000) $display("FAIL lockup_forced: got %h want %h", random, 9'h000);
    else n_pass++;
`ifdef LFSR9_LOCKUP_RECOVERY_EN
    step();
    n_total++;
    if (random !== 9'h001) $display("FAIL lockup_recover: got %h want %h", random, 9'h001);
    else n_pass++;
    step();
    n_total++;
    if (random !== 9'h002) $display("FAIL lockup_next: got %h want %h", random, 9'h002);
    else n_pass++;
`else
    for (int i = 0; i < 10; i++) begin
      step();
      n_total++;
      if (random !== 9'h000) $display("FAIL lockup_stuck[%0d]: got %h want %h", i, random, 9'h000);
      else n_pass++;
    end
`endif
    reset = 1'b1;
    step();
    n_total++;
    if (random !== 9'h001) $display("FAIL lockup_reset: got %h want %h", random, 9'h001);
    else n_pass++;
    reset = 1'b0;
    step();
    n_total++;
    if (random !== 9'h002) $display("FAIL lockup_resume: got %h want %h", random, 9'h002);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    test_reset();
    test_first_steps();
    test_full_period();
    test_mid_reset();
    test_seed();
    test_lockup();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
